// File: rtl/conv_psum_accum_if.sv
// Handshake and configuration bundle between the partial-sum accumulator and its neighbours.
// The accumulator uses the slave view; the driving side (configuration, product source, quantizer) uses master.
interface conv_psum_accum_if #(
   parameter int unsigned PROD_WIDTH  = 16,
   parameter int unsigned ACC_WIDTH   = 32,
   parameter int unsigned BIAS_WIDTH  = 32,
   parameter int unsigned SCALE_WIDTH = 16,
   parameter int unsigned NUM_CH      = 8
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   logic                   cfg_we;
   logic [CH_W-1:0]        cfg_addr;
   logic [BIAS_WIDTH-1:0]  cfg_bias;
   logic [SCALE_WIDTH-1:0] cfg_scale;

   logic                   prod_valid;
   logic                   prod_ready;
   logic [PROD_WIDTH-1:0]  prod_data;

   logic                   acc_valid;
   logic                   acc_ready;
   logic [ACC_WIDTH-1:0]   acc_data;
   logic [BIAS_WIDTH-1:0]  acc_bias;
   logic [SCALE_WIDTH-1:0] acc_scale;
   logic [CH_W-1:0]        acc_ch;

   modport master (
      output cfg_we, cfg_addr, cfg_bias, cfg_scale,
      output prod_valid, prod_data, acc_ready,
      input  prod_ready, acc_valid, acc_data, acc_bias, acc_scale, acc_ch
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_bias, cfg_scale,
      input  prod_valid, prod_data, acc_ready,
      output prod_ready, acc_valid, acc_data, acc_bias, acc_scale, acc_ch
   );
endinterface

// File: rtl/conv_psum_accum.sv
// Accumulates KERNEL_LEN signed products per output channel and emits {sum, bias, scale, ch}
// records through a single output register; bias/scale come from a software-written table.
module conv_psum_accum #(
   parameter int unsigned PROD_WIDTH  = 16,
   parameter int unsigned ACC_WIDTH   = 32,
   parameter int unsigned BIAS_WIDTH  = 32,
   parameter int unsigned SCALE_WIDTH = 16,
   parameter int unsigned KERNEL_LEN  = 9,
   parameter int unsigned NUM_CH      = 8
) (
   input logic clk,
   input logic rst,
   conv_psum_accum_if.slave bus
);
   localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int unsigned K_W  = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
   localparam logic [K_W-1:0]         K_LAST    = K_W'(KERNEL_LEN - 1);
   localparam logic [CH_W-1:0]        CH_LAST   = CH_W'(NUM_CH - 1);
   localparam logic [CH_W:0]          CH_COUNT  = (CH_W + 1)'(NUM_CH);
   localparam logic [SCALE_WIDTH-1:0] SCALE_ONE = SCALE_WIDTH'(256);

   logic [ACC_WIDTH-1:0]   acc;
   logic [K_W-1:0]         k;
   logic [CH_W-1:0]        ch;

   logic [BIAS_WIDTH-1:0]  bias_tbl  [NUM_CH];
   logic [SCALE_WIDTH-1:0] scale_tbl [NUM_CH];

   logic                   out_valid;
   logic [ACC_WIDTH-1:0]   out_data;
   logic [BIAS_WIDTH-1:0]  out_bias;
   logic [SCALE_WIDTH-1:0] out_scale;
   logic [CH_W-1:0]        out_ch;

   logic                   last_k;
   logic                   ready;
   logic                   accept;
   logic                   final_prod;
   logic                   cfg_hit;
   logic [ACC_WIDTH-1:0]   prod_ext;
   logic [ACC_WIDTH-1:0]   sum;

   // Only the final product can stall: it needs the output register free or draining.
   assign last_k     = (k == K_LAST);
   assign ready      = !(last_k && out_valid && !bus.acc_ready);
   assign accept     = bus.prod_valid && ready;
   assign final_prod = accept && last_k;
   assign prod_ext   = ACC_WIDTH'($signed(bus.prod_data));
   assign sum        = acc + prod_ext;
   assign cfg_hit    = bus.cfg_we && ({1'b0, bus.cfg_addr} < CH_COUNT);

   assign bus.prod_ready = ready;
   assign bus.acc_valid  = out_valid;
   assign bus.acc_data   = out_data;
   assign bus.acc_bias   = out_bias;
   assign bus.acc_scale  = out_scale;
   assign bus.acc_ch     = out_ch;

   // Running sum and kernel/channel position.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         k   <= '0;
         ch  <= '0;
      end else if (accept) begin
         if (last_k) begin
            acc <= '0;
            k   <= '0;
            ch  <= (ch == CH_LAST) ? '0 : ch + CH_W'(1);
         end else begin
            acc <= sum;
            k   <= k + K_W'(1);
         end
      end
   end

   // Output register: a new record may load in the same cycle the previous one drains.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_bias  <= '0;
         out_scale <= '0;
         out_ch    <= '0;
      end else if (final_prod) begin
         out_valid <= 1'b1;
         out_data  <= sum;
         out_bias  <= bias_tbl[ch];
         out_scale <= scale_tbl[ch];
         out_ch    <= ch;
      end else if (out_valid && bus.acc_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Per-channel bias/scale table; a same-cycle capture sees the pre-write entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            bias_tbl[i]  <= '0;
            scale_tbl[i] <= SCALE_ONE;
         end
      end else if (cfg_hit) begin
         bias_tbl[bus.cfg_addr]  <= bus.cfg_bias;
         scale_tbl[bus.cfg_addr] <= bus.cfg_scale;
      end
   end
endmodule

// File: doc/conv_psum_accum.md
# conv_psum_accum

Accumulates a stream of signed MAC products into per-output-channel partial sums. After every KERNEL_LEN products it emits one {sum, bias, scale} record on a valid/ready interface. This is the transmitting end of the post-processing stage: its output port drives the data/bias/scale inputs and input handshake of the bias/scale/ReLU quantizer. Per-channel bias and Q8.8 scale come from an internal table that software writes through a configuration port.

## Interface
- PROD_WIDTH, 16, signed product width
- ACC_WIDTH, 32, signed accumulator and output sum width
- BIAS_WIDTH, 32, signed bias width
- SCALE_WIDTH, 16, signed Q8.8 scale width
- KERNEL_LEN, 9, products per output sum (≥2)
- NUM_CH, 8, output channels, i.e. table depth (≥2)
- CH_W, $clog2(NUM_CH), channel index width (derived)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  CH_W  table entry index
- cfg_bias  in  BIAS_WIDTH  bias to write
- cfg_scale  in  SCALE_WIDTH  scale to write
- prod_valid  in  1  product available
- prod_ready  out  1  product accepted this cycle when high with prod_valid
- prod_data  in  PROD_WIDTH  signed product
- acc_valid  out  1  output record valid
- acc_ready  in  1  downstream can take the record
- acc_data  out  ACC_WIDTH  completed sum
- acc_bias  out  BIAS_WIDTH  bias of channel acc_ch
- acc_scale  out  SCALE_WIDTH  scale of channel acc_ch
- acc_ch  out  CH_W  channel index of the record

## Operation
- Internal state:
  - running sum `acc` (ACC_WIDTH)
  - product counter `k` (0..KERNEL_LEN-1)
  - channel counter `ch` (0..NUM_CH-1)
  - one output register set: acc_data/bias/scale/ch plus acc_valid
- Product acceptance: a product is accepted when `prod_valid && prod_ready`.
  - prod_data is sign-extended to ACC_WIDTH and added.
  - Arithmetic wraps in two's complement. There is no saturation.
- Non-final product (`k < KERNEL_LEN-1`): `acc <= acc + p`, `k <= k+1`.
- Final product (`k == KERNEL_LEN-1`), in the same clock edge:
  - acc_data <= acc + p
  - acc_bias/acc_scale <= table[ch]
  - acc_ch <= ch
  - acc_valid <= 1
  - acc <= 0, k <= 0
  - ch <= (ch == NUM_CH-1) ? 0 : ch+1
- Output drain: on `acc_valid && acc_ready` with no final product in the same cycle, acc_valid <= 0.
- Final product arriving while the output register drains in the same cycle: the new record loads and acc_valid stays 1. There is no bubble.
- prod_ready = !(k == KERNEL_LEN-1 && acc_valid && !acc_ready). It is combinational on acc_ready. Non-final products are always accepted, so accumulation overlaps output backpressure.
- Table write: on cfg_we, table[cfg_addr] <= {cfg_bias, cfg_scale}.
  - If a write and a capture hit the same entry in the same cycle, the capture takes the old value.
  - Out-of-range cfg_addr (≥ NUM_CH) is ignored.
- A single-entry output register (no FIFO) is required.

## Timing
- Reset values:
  - acc_valid 0; acc_data, acc_bias, acc_scale, acc_ch all 0
  - acc 0, k 0, ch 0
  - every table entry: bias 0, scale 16'h0100 (1.0)
  - prod_ready is 1 as soon as reset is released
- Latency: acc_valid rises the cycle after the edge that accepts the final product.
- acc_data/acc_bias/acc_scale/acc_ch must be stable while `acc_valid && !acc_ready`.
- acc_valid must not drop without a handshake.
- Throughput: one record per KERNEL_LEN accepted products, sustained when acc_ready is held high.
- Reset mid-kernel discards the partial sum and any pending record.

## Test plan
- Configure ch0 {bias=100, scale=0x0080}, feed 9 products of +3, acc_ready=1 -> one record: acc_data=27, acc_bias=100, acc_scale=0x0080, acc_ch=0, one cycle after the 9th accept; prod_ready never low.
- Feed 9 products of -32768 -> acc_data=-294912 (0xFFFB8000).
- Hold acc_ready=0 and stream 18 products -> the first record is held stable; products 10-17 are accepted; prod_ready=0 at the 18th. Raise acc_ready -> the 18th is accepted in that same cycle, and the second record (ch=1) loads with no gap in acc_valid.
- Stream 9×NUM_CH+9 products of +1 -> acc_ch sequence is 0..7,0; all acc_data=9; each record's bias/scale matches its table entry.
- Write ch2 bias=5 in the same cycle the ch2 record is captured (previously bias=0) -> record shows bias 0; the next ch2 record (after wrap) shows 5.
- Assert rst after 4 of 9 products, then feed 9 products of +2 -> acc_data=18, acc_ch=0, table back to defaults (bias 0, scale 0x0100).
